// File: rtl/cla_pkg.sv
// Shared helpers and pipeline record types for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 << r) < value) begin
                r = r + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// One SEG-bit adder segment: BLOCK-wide P/G lookahead groups joined by a group-level carry chain.
module cla_segment #(
    parameter int SEG   = 16,
    parameter int BLOCK = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb_in
);
    localparam int NG = SEG / BLOCK;

    logic [SEG-1:0] p_s;
    logic [SEG-1:0] g_s;
    logic [SEG-1:0] c_s;
    logic [NG:0]    gc_s;
    logic           grp_p_s;
    logic           grp_g_s;
    logic           term_s;
    logic           cry_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Per group: flat lookahead for group P/G and for every in-group carry; only groups ripple.
    always_comb begin
        gc_s    = '0;
        c_s     = '0;
        grp_p_s = 1'b1;
        grp_g_s = 1'b0;
        term_s  = 1'b0;
        cry_s   = 1'b0;
        gc_s[0] = cin;
        for (int j = 0; j < NG; j++) begin
            grp_p_s = 1'b1;
            grp_g_s = 1'b0;
            for (int i = 0; i < BLOCK; i++) begin
                term_s = g_s[j*BLOCK+i];
                for (int m = i + 1; m < BLOCK; m++) begin
                    term_s = term_s & p_s[j*BLOCK+m];
                end
                grp_g_s = grp_g_s | term_s;
                grp_p_s = grp_p_s & p_s[j*BLOCK+i];
            end
            for (int i = 0; i < BLOCK; i++) begin
                term_s = gc_s[j];
                for (int m = 0; m < i; m++) begin
                    term_s = term_s & p_s[j*BLOCK+m];
                end
                cry_s = term_s;
                for (int n = 0; n < i; n++) begin
                    term_s = g_s[j*BLOCK+n];
                    for (int m = n + 1; m < i; m++) begin
                        term_s = term_s & p_s[j*BLOCK+m];
                    end
                    cry_s = cry_s | term_s;
                end
                c_s[j*BLOCK+i] = cry_s;
            end
            gc_s[j+1] = grp_g_s | (grp_p_s & gc_s[j]);
        end
    end

    assign sum      = p_s ^ c_s;
    assign cout     = gc_s[NG];
    assign c_msb_in = c_s[SEG-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one segment per stage, global stall on backpressure.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int SEG = seg_width(WIDTH, STAGES);

    if ((STAGES < 1) || ((WIDTH % (STAGES * BLOCK)) != 0)) begin : g_param_check
        $fatal(1, "cla_adder_pipe: WIDTH must be a multiple of STAGES*BLOCK");
    end

    logic             adv_s;
    logic             acc_load_s;
    stage_ctl_t       acc_ctl_d, acc_ctl_q;
    logic [WIDTH-1:0] acc_a_d, acc_a_q;
    logic [WIDTH-1:0] acc_b_d, acc_b_q;

    assign adv_s      = ~out_valid | out_ready;
    assign in_ready   = adv_s;
    assign acc_load_s = adv_s & in_valid;

    // Acceptance register: operands captured with subtract already folded into b and carry-in.
    always_comb begin
        acc_ctl_d = acc_ctl_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        if (adv_s) begin
            acc_ctl_d.valid = in_valid;
        end else begin
            acc_ctl_d.valid = acc_ctl_q.valid;
        end
        if (acc_load_s) begin
            acc_ctl_d.carry = in_sub ? 1'b1 : in_cin;
            acc_a_d         = in_a;
            acc_b_d         = in_sub ? ~in_b : in_b;
        end else begin
            acc_ctl_d.carry = acc_ctl_q.carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_ctl_q <= '0;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
        end else begin
            acc_ctl_q <= acc_ctl_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SRC_W  = WIDTH - k * SEG;
        localparam int DONE_W = (k + 1) * SEG;

        logic [SRC_W-1:0]  src_a_s, src_b_s;
        logic              src_cin_s, src_valid_s;
        logic [SEG-1:0]    seg_sum_s;
        logic              seg_cout_s, seg_cmsb_s, load_s;
        logic [DONE_W-1:0] done_s;
        stage_ctl_t        ctl_d, ctl_q;
        logic [DONE_W-1:0] sum_d, sum_q;

        if (k == 0) begin : g_src
            assign src_a_s     = acc_a_q;
            assign src_b_s     = acc_b_q;
            assign src_cin_s   = acc_ctl_q.carry;
            assign src_valid_s = acc_ctl_q.valid;
            assign done_s      = seg_sum_s;
        end else begin : g_src
            assign src_a_s     = g_stg[k-1].g_fwd.a_rem_q;
            assign src_b_s     = g_stg[k-1].g_fwd.b_rem_q;
            assign src_cin_s   = g_stg[k-1].ctl_q.carry;
            assign src_valid_s = g_stg[k-1].ctl_q.valid;
            assign done_s      = {seg_sum_s, g_stg[k-1].sum_q};
        end

        cla_segment #(.SEG(SEG), .BLOCK(BLOCK)) u_seg (
            .a        (src_a_s[SEG-1:0]),
            .b        (src_b_s[SEG-1:0]),
            .cin      (src_cin_s),
            .sum      (seg_sum_s),
            .cout     (seg_cout_s),
            .c_msb_in (seg_cmsb_s)
        );

        assign load_s = adv_s & src_valid_s;

        // Valid moves with the global advance; payload only loads on a real beat.
        always_comb begin
            ctl_d = ctl_q;
            sum_d = sum_q;
            if (adv_s) begin
                ctl_d.valid = src_valid_s;
            end else begin
                ctl_d.valid = ctl_q.valid;
            end
            if (load_s) begin
                ctl_d.carry = seg_cout_s;
                sum_d       = done_s;
            end else begin
                ctl_d.carry = ctl_q.carry;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q <= '0;
                sum_q <= '0;
            end else begin
                ctl_q <= ctl_d;
                sum_q <= sum_d;
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_d, ovf_q, loaded_d, loaded_q;

            // Overflow from the final segment; loaded keeps out_zero low until a result exists.
            always_comb begin
                if (load_s) begin
                    ovf_d = seg_cmsb_s ^ seg_cout_s;
                end else begin
                    ovf_d = ovf_q;
                end
                loaded_d = loaded_q | load_s;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q    <= 1'b0;
                    loaded_q <= 1'b0;
                end else begin
                    ovf_q    <= ovf_d;
                    loaded_q <= loaded_d;
                end
            end
        end else begin : g_fwd
            localparam int REM_W = SRC_W - SEG;
            logic [REM_W-1:0] a_rem_d, a_rem_q, b_rem_d, b_rem_q;
            logic             cmsb_unused_s;

            assign cmsb_unused_s = seg_cmsb_s;

            // Operand bits not yet summed are skewed forward to the next segment.
            always_comb begin
                if (load_s) begin
                    a_rem_d = src_a_s[SRC_W-1:SEG];
                    b_rem_d = src_b_s[SRC_W-1:SEG];
                end else begin
                    a_rem_d = a_rem_q;
                    b_rem_d = b_rem_q;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].ctl_q.valid;
    assign out_sum   = g_stg[STAGES-1].sum_q;
    assign out_cout  = g_stg[STAGES-1].ctl_q.carry;
    assign out_ovf   = g_stg[STAGES-1].g_last.ovf_q;
    assign out_zero  = g_stg[STAGES-1].g_last.loaded_q & ~(|out_sum);

endmodule
